switch_depacketizer: RTL and testbench
======================================

SWITCH_DEPACKETIZER -- requirements
Module: switch_depacketizer

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, 64, Ethernet beat data width; ADDRESS_WIDTH, 4, router address width; VC_ADDRESS_WIDTH, 1, VC field width; WIDTH_IN, 600, NoC flit width.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; one clock, reset asynchronous and active-low.
REQ-004 i_data_in  input  WIDTH_IN  NoC flit from the switch egress port.
REQ-005 i_valid_in  input  1  NoC flit valid.
REQ-006 i_ready_out  output  1  block can accept a NoC flit this cycle.
REQ-007 o_data_out  output  DATA_WIDTH  Ethernet beat data.
REQ-008 o_sop_out / o_eop_out  output  1 each  start/end of Ethernet packet.
REQ-009 o_empty_out  output  3  empty byte count of the beat.
REQ-010 o_error_out  output  1  Ethernet error flag of the beat.
REQ-011 o_dest_out  output  ADDRESS_WIDTH  destination field of the source NoC flit.
REQ-012 o_vc_out  output  VC_ADDRESS_WIDTH  VC field of the source NoC flit.
REQ-013 o_valid_out  output  1  Ethernet beat valid.
REQ-014 o_ready_in  input  1  downstream accepts the beat.
REQ-015 o_proto_err  output  1  sticky protocol-violation flag.

Function
REQ-016 Flit layout (Q=WIDTH_IN/4), top-down from bit WIDTH_IN-1: valid, head, tail, VC, dest, field1, field2, 4 zero bits; bits below WIDTH_IN-Q SHALL be ignored (defaults: 599 valid, 598 head, 597 tail, 596 VC, 595:592 dest, 591:523 field1, 522:454 field2).
REQ-017 Each field SHALL be DATA_WIDTH+5 bits: [MSB]=eop, then data, then empty[2:0], then error at [0].
REQ-018 NoC transfer SHALL occur on a cycle with i_valid_in && i_ready_out; transfers with embedded valid bit 0 SHALL be consumed and discarded with no beat produced.
REQ-019 A kept flit SHALL be registered whole and emitted as beat1 (field1, o_sop_out=head) then, only if field1 eop=0, beat2 (field2, o_sop_out=0).
REQ-020 State machine: EMPTY -> BEAT1 on kept transfer; BEAT1 -> BEAT2 on beat accept when field1 eop=0; BEAT1 -> EMPTY on accept when field1 eop=1; BEAT2 -> EMPTY on accept; any accept that empties the buffer SHALL go directly to BEAT1 if a kept transfer occurs that same cycle.
REQ-021 i_ready_out SHALL be 1 in EMPTY, and equal o_ready_in in BEAT2 or in BEAT1 with field1 eop=1; 0 otherwise.
REQ-022 o_valid_out SHALL be 1 exactly in BEAT1/BEAT2; beat fields, o_dest_out, o_vc_out SHALL be held stable while o_valid_out && !o_ready_in.
REQ-023 Latency: beat1 SHALL be presented the cycle after transfer; beat2 the cycle after beat1 accept; sustained throughput one beat per cycle.
REQ-024 o_dest_out/o_vc_out SHALL carry the registered flit's fields for both beats.
REQ-025 An in_packet register SHALL set on an emitted beat with sop=1 and eop=0 and clear on an emitted beat with eop=1.
REQ-026 o_proto_err SHALL set (and hold until reset) on a kept flit with: head=1 while in_packet; head=0 while !in_packet; tail != (field1 eop || field2 eop).
REQ-027 Flagged flits SHALL still be emitted unchanged.

Reset
REQ-028 rst_n low SHALL immediately force state EMPTY, in_packet 0, o_proto_err 0, o_valid_out 0, all beat outputs, o_dest_out, o_vc_out 0; i_ready_out SHALL be 0 while rst_n low.
REQ-029 Reset mid-packet (BEAT1/BEAT2) SHALL discard the buffered flit; first kept flit after release with head=1 SHALL be accepted without o_proto_err.

Verification
REQ-030 Single-beat: head=1, tail=1, field1 eop=1, data 64'hDEADBEEF_CAFEF00D, empty=3 -> one beat sop=1 eop=1 empty=3 next cycle, no beat2, i_ready_out=1 same cycle as accept.
REQ-031 Two-beat stream: 3 back-to-back flits (head 1,0,0; last tail=1, field2 eop=1), o_ready_in=1 -> 6 beats on 6 consecutive cycles, sop only on beat 1, eop only on beat 6, o_proto_err=0.
REQ-032 Backpressure: o_ready_in=0 for 3 cycles in BEAT2 -> outputs stable, i_ready_out=0; release -> beat2 accepted, next flit beat1 following cycle.
REQ-033 Embedded valid=0 with i_valid_in=1 -> transfer consumed, o_valid_out stays 0.
REQ-034 Head=1 flit while in_packet, and tail=1 with both field eops 0 -> o_proto_err=1, remains 1 until rst_n low.
REQ-035 rst_n asserted during BEAT2 -> o_valid_out=0 without clock edge; after release, new head flit emits sop=1 beat, o_proto_err=0.

Source files
------------

// File: rtl/switch_depacketizer.sv
// Converts one NoC flit from a switch egress port into one or two Ethernet beats.
// Also tracks packet framing and flags protocol violations in a sticky error bit.
module switch_depacketizer #(
    parameter int DATA_WIDTH       = 64,
    parameter int ADDRESS_WIDTH    = 4,
    parameter int VC_ADDRESS_WIDTH = 1,
    parameter int WIDTH_IN         = 600
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [WIDTH_IN-1:0]         i_data_in,
    input  logic                        i_valid_in,
    output logic                        i_ready_out,
    output logic [DATA_WIDTH-1:0]       o_data_out,
    output logic                        o_sop_out,
    output logic                        o_eop_out,
    output logic [2:0]                  o_empty_out,
    output logic                        o_error_out,
    output logic [ADDRESS_WIDTH-1:0]    o_dest_out,
    output logic [VC_ADDRESS_WIDTH-1:0] o_vc_out,
    output logic                        o_valid_out,
    input  logic                        o_ready_in,
    output logic                        o_proto_err
);

    localparam int FW        = DATA_WIDTH + 5;
    localparam int P_VALID   = WIDTH_IN - 1;
    localparam int P_HEAD    = WIDTH_IN - 2;
    localparam int P_TAIL    = WIDTH_IN - 3;
    localparam int P_VC_LO   = WIDTH_IN - 3 - VC_ADDRESS_WIDTH;
    localparam int P_DEST_LO = P_VC_LO - ADDRESS_WIDTH;
    localparam int P_F1_LO   = P_DEST_LO - FW;
    localparam int P_F2_LO   = P_F1_LO - FW;

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_BEAT1 = 2'd1;
    localparam logic [1:0] S_BEAT2 = 2'd2;

    logic [1:0]                  r_state;
    logic                        r_head;
    logic [VC_ADDRESS_WIDTH-1:0] r_vc;
    logic [ADDRESS_WIDTH-1:0]    r_dest;
    logic [FW-1:0]               r_f1;
    logic [FW-1:0]               r_f2;
    logic                        r_in_packet;
    logic                        r_proto_err;

    logic [FW-1:0] w_in_f1;
    logic [FW-1:0] w_in_f2;
    logic          w_in_head;
    logic          w_in_tail;
    logic [FW-1:0] w_cur;
    logic          w_f1_eop;
    logic          w_accept;
    logic          w_drain;
    logic          w_keep;
    logic          w_in_pkt_next;
    logic          w_viol;
    logic [1:0]    w_state_nxt;
    logic          w_unused;

    assign w_in_f1   = i_data_in[P_F1_LO +: FW];
    assign w_in_f2   = i_data_in[P_F2_LO +: FW];
    assign w_in_head = i_data_in[P_HEAD];
    assign w_in_tail = i_data_in[P_TAIL];
    assign w_unused  = ^i_data_in[P_F2_LO-1:0];

    assign w_f1_eop    = r_f1[FW-1];
    assign w_cur       = (r_state == S_BEAT2) ? r_f2 : r_f1;
    assign o_valid_out = (r_state == S_BEAT1) || (r_state == S_BEAT2);

    assign o_data_out  = o_valid_out ? w_cur[FW-2:4] : '0;
    assign o_eop_out   = o_valid_out & w_cur[FW-1];
    assign o_empty_out = o_valid_out ? w_cur[3:1] : '0;
    assign o_error_out = o_valid_out & w_cur[0];
    assign o_sop_out   = (r_state == S_BEAT1) & r_head;
    assign o_dest_out  = r_dest;
    assign o_vc_out    = r_vc;
    assign o_proto_err = r_proto_err;

    // A flit may be taken in the same cycle the last buffered beat leaves.
    assign w_accept    = o_valid_out & o_ready_in;
    assign w_drain     = w_accept & ((r_state == S_BEAT2) | w_f1_eop);
    assign i_ready_out = rst_n & ((r_state == S_EMPTY) | w_drain);
    assign w_keep      = i_valid_in & i_ready_out & i_data_in[P_VALID];

    // Framing is judged against in_packet as updated by this cycle's beat,
    // so a head flit arriving alongside the previous packet's last beat is legal.
    always_comb begin
        w_in_pkt_next = r_in_packet;
        if (w_accept) begin
            if (o_eop_out)
                w_in_pkt_next = 1'b0;
            else if (o_sop_out)
                w_in_pkt_next = 1'b1;
        end
    end

    assign w_viol = (w_in_head == w_in_pkt_next) |
                    (w_in_tail != (w_in_f1[FW-1] | w_in_f2[FW-1]));

    always_comb begin
        w_state_nxt = r_state;
        if (w_keep)
            w_state_nxt = S_BEAT1;
        else if (w_accept)
            w_state_nxt = ((r_state == S_BEAT1) && !w_f1_eop) ? S_BEAT2 : S_EMPTY;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_EMPTY;
            r_head      <= 1'b0;
            r_vc        <= '0;
            r_dest      <= '0;
            r_f1        <= '0;
            r_f2        <= '0;
            r_in_packet <= 1'b0;
            r_proto_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_packet <= w_in_pkt_next;
            if (w_keep) begin
                r_head <= w_in_head;
                r_vc   <= i_data_in[P_VC_LO +: VC_ADDRESS_WIDTH];
                r_dest <= i_data_in[P_DEST_LO +: ADDRESS_WIDTH];
                r_f1   <= w_in_f1;
                r_f2   <= w_in_f2;
                if (w_viol)
                    r_proto_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_switch_depacketizer.sv
// Directed bench for switch_depacketizer: beats are predicted into a queue
// when flits are driven and compared as the DUT hands them downstream.
module tb_switch_depacketizer;

    localparam int WI = 600;
    localparam int FW = 69;

    typedef struct packed {
        logic [63:0] data;
        logic        sop;
        logic        eop;
        logic [2:0]  empty;
        logic        err;
        logic [3:0]  dest;
        logic        vc;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [WI-1:0] i_data_in;
    logic          i_valid_in;
    logic          i_ready_out;
    logic [63:0]   o_data_out;
    logic          o_sop_out, o_eop_out, o_error_out, o_valid_out, o_ready_in, o_proto_err;
    logic [2:0]    o_empty_out;
    logic [3:0]    o_dest_out;
    logic [0:0]    o_vc_out;

    beat_t q[$];
    int errors = 0;
    int checks = 0;
    int beat_cnt = 0;
    int cyc = 0;
    int acc_cyc[256];

    switch_depacketizer #(
        .DATA_WIDTH(64), .ADDRESS_WIDTH(4), .VC_ADDRESS_WIDTH(1), .WIDTH_IN(600)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_data_in(i_data_in), .i_valid_in(i_valid_in),
        .i_ready_out(i_ready_out), .o_data_out(o_data_out), .o_sop_out(o_sop_out),
        .o_eop_out(o_eop_out), .o_empty_out(o_empty_out), .o_error_out(o_error_out),
        .o_dest_out(o_dest_out), .o_vc_out(o_vc_out), .o_valid_out(o_valid_out),
        .o_ready_in(o_ready_in), .o_proto_err(o_proto_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [FW-1:0] fld(input logic eop, input logic [63:0] d,
                                          input logic [2:0] e, input logic er);
        return {eop, d, e, er};
    endfunction

    // Low quarter of the flit is filled with junk the DUT must ignore.
    function automatic logic [WI-1:0] mk(input logic v, input logic h, input logic t,
                                         input logic vc, input logic [3:0] dest,
                                         input logic [FW-1:0] f1, input logic [FW-1:0] f2);
        logic [WI-1:0] r;
        r = '0;
        r[31:0]    = $urandom();
        r[231:200] = $urandom();
        r[449:418] = $urandom();
        r[599] = v;
        r[598] = h;
        r[597] = t;
        r[596] = vc;
        r[595:592] = dest;
        r[591:523] = f1;
        r[522:454] = f2;
        return r;
    endfunction

    task automatic push_exp(input logic [WI-1:0] f);
        beat_t b;
        b.dest = f[595:592];
        b.vc   = f[596];
        b.sop  = f[598];
        b.eop  = f[591];
        b.data = f[590:527];
        b.empty = f[526:524];
        b.err  = f[523];
        q.push_back(b);
        if (!f[591]) begin
            b.sop  = 1'b0;
            b.eop  = f[522];
            b.data = f[521:458];
            b.empty = f[457:455];
            b.err  = f[454];
            q.push_back(b);
        end
    endtask

    task automatic send(input logic [WI-1:0] f, input string tag);
        logic done;
        int n;
        done = 1'b0;
        n = 0;
        i_data_in  = f;
        i_valid_in = 1'b1;
        while (!done && n < 50) begin
            @(negedge clk);
            if (i_ready_out) done = 1'b1;
            @(posedge clk); #1;
            n++;
        end
        i_valid_in = 1'b0;
        chk({tag, "_xfer"}, 64'(done), 64'd1);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((q.size() != 0 || o_valid_out) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_drain"}, 64'(q.size()), 64'd0);
    endtask

    always @(negedge clk) begin
        if (rst_n && o_valid_out && o_ready_in) begin
            beat_t e;
            chk("sb_nonempty", 64'(q.size() > 0), 64'd1);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("beat_data", o_data_out, e.data);
                chk("beat_sop", 64'(o_sop_out), 64'(e.sop));
                chk("beat_eop", 64'(o_eop_out), 64'(e.eop));
                chk("beat_empty", 64'(o_empty_out), 64'(e.empty));
                chk("beat_err", 64'(o_error_out), 64'(e.err));
                chk("beat_dest", 64'(o_dest_out), 64'(e.dest));
                chk("beat_vc", 64'(o_vc_out), 64'(e.vc));
            end
            acc_cyc[beat_cnt % 256] = cyc;
            beat_cnt++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WI-1:0] f, fa, fb;
        int base;
        rst_n = 1'b0;
        i_valid_in = 1'b0;
        i_data_in = '0;
        o_ready_in = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 64'(o_valid_out), 64'd0);
        chk("rst_ready", 64'(i_ready_out), 64'd0);
        chk("rst_proto", 64'(o_proto_err), 64'd0);
        chk("rst_data", o_data_out, 64'd0);
        chk("rst_dest", 64'(o_dest_out), 64'd0);
        rst_n = 1'b1;
        #1;
        chk("empty_ready", 64'(i_ready_out), 64'd1);
        @(posedge clk); #1;

        // Single-beat packet
        f = mk(1, 1, 1, 0, 4'h5, fld(1, 64'hDEADBEEF_CAFEF00D, 3'd3, 0), fld(0, 64'h1111, 0, 0));
        push_exp(f);
        i_data_in = f;
        i_valid_in = 1'b1;
        @(negedge clk);
        chk("t1_ready", 64'(i_ready_out), 64'd1);
        @(posedge clk); #1;
        i_valid_in = 1'b0;
        chk("t1_valid", 64'(o_valid_out), 64'd1);
        chk("t1_sop", 64'(o_sop_out), 64'd1);
        chk("t1_eop", 64'(o_eop_out), 64'd1);
        chk("t1_empty", 64'(o_empty_out), 64'd3);
        chk("t1_data", o_data_out, 64'hDEADBEEF_CAFEF00D);
        @(posedge clk); #1;
        chk("t1_no_beat2", 64'(o_valid_out), 64'd0);

        // Three back-to-back two-beat flits forming one packet
        base = beat_cnt;
        f = mk(1, 1, 0, 1, 4'hA, fld(0, 64'hA1, 0, 0), fld(0, 64'hA2, 1, 1));
        push_exp(f); send(f, "t2_f1");
        f = mk(1, 0, 0, 1, 4'hA, fld(0, 64'hA3, 2, 0), fld(0, 64'hA4, 0, 0));
        push_exp(f); send(f, "t2_f2");
        f = mk(1, 0, 1, 1, 4'hA, fld(0, 64'hA5, 0, 1), fld(1, 64'hA6, 2, 0));
        push_exp(f); send(f, "t2_f3");
        drain("t2");
        chk("t2_beats", 64'(beat_cnt - base), 64'd6);
        chk("t2_span", 64'(acc_cyc[(base + 5) % 256] - acc_cyc[base % 256]), 64'd5);
        chk("t2_proto", 64'(o_proto_err), 64'd0);

        // Backpressure in BEAT2 with the next flit waiting
        fa = mk(1, 1, 1, 0, 4'h3, fld(0, 64'hB1, 1, 0), fld(1, 64'hB2B2_0000_1234_5678, 3'd4, 1));
        fb = mk(1, 1, 1, 1, 4'h7, fld(1, 64'hC0FFEE, 0, 0), fld(0, 64'h0, 0, 0));
        push_exp(fa);
        i_data_in = fa;
        i_valid_in = 1'b1;
        @(posedge clk); #1;
        push_exp(fb);
        i_data_in = fb;
        @(posedge clk); #1;
        o_ready_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t3_stall_ready", 64'(i_ready_out), 64'd0);
            chk("t3_stall_valid", 64'(o_valid_out), 64'd1);
            chk("t3_stall_data", o_data_out, 64'hB2B2_0000_1234_5678);
            chk("t3_stall_empty", 64'(o_empty_out), 64'd4);
            chk("t3_stall_dest", 64'(o_dest_out), 64'd3);
            @(posedge clk); #1;
        end
        o_ready_in = 1'b1;
        @(negedge clk);
        chk("t3_release_ready", 64'(i_ready_out), 64'd1);
        @(posedge clk); #1;
        i_valid_in = 1'b0;
        chk("t3_next_valid", 64'(o_valid_out), 64'd1);
        chk("t3_next_sop", 64'(o_sop_out), 64'd1);
        chk("t3_next_data", o_data_out, 64'hC0FFEE);
        chk("t3_next_dest", 64'(o_dest_out), 64'd7);
        drain("t3");
        chk("t3_proto", 64'(o_proto_err), 64'd0);

        // Embedded valid=0: consumed, nothing emitted
        i_data_in = mk(0, 1, 1, 0, 4'h2, fld(1, 64'h55, 0, 0), fld(0, 64'h0, 0, 0));
        i_valid_in = 1'b1;
        @(negedge clk);
        chk("t4_ready", 64'(i_ready_out), 64'd1);
        @(posedge clk); #1;
        i_valid_in = 1'b0;
        chk("t4_no_beat_a", 64'(o_valid_out), 64'd0);
        @(posedge clk); #1;
        chk("t4_no_beat_b", 64'(o_valid_out), 64'd0);

        // Tail set while neither field carries eop
        f = mk(1, 1, 1, 0, 4'h2, fld(0, 64'hD1, 0, 0), fld(0, 64'hD2, 0, 0));
        push_exp(f); send(f, "t5");
        chk("t5_proto_set", 64'(o_proto_err), 64'd1);
        drain("t5");
        repeat (3) @(posedge clk);
        #1;
        chk("t5_proto_hold", 64'(o_proto_err), 64'd1);

        // Reset while BEAT2 is stalled
        f = mk(1, 0, 1, 0, 4'h9, fld(0, 64'hE1, 0, 0), fld(1, 64'hE2, 0, 0));
        push_exp(f);
        i_data_in = f;
        i_valid_in = 1'b1;
        @(posedge clk); #1;
        i_valid_in = 1'b0;
        @(posedge clk); #1;
        o_ready_in = 1'b0;
        #2;
        chk("t6_pre_valid", 64'(o_valid_out), 64'd1);
        chk("t6_pre_proto", 64'(o_proto_err), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 64'(o_valid_out), 64'd0);
        chk("t6_rst_ready", 64'(i_ready_out), 64'd0);
        chk("t6_rst_proto", 64'(o_proto_err), 64'd0);
        chk("t6_rst_data", o_data_out, 64'd0);
        chk("t6_rst_dest", 64'(o_dest_out), 64'd0);
        chk("t6_rst_eop", 64'(o_eop_out), 64'd0);
        q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        o_ready_in = 1'b1;
        f = mk(1, 1, 1, 1, 4'hC, fld(1, 64'hF00D, 3'd5, 1), fld(0, 64'h0, 0, 0));
        push_exp(f); send(f, "t6");
        chk("t6_sop", 64'(o_sop_out), 64'd1);
        chk("t6_proto", 64'(o_proto_err), 64'd0);
        drain("t6");

        // Head flit while a packet is open
        f = mk(1, 1, 0, 0, 4'h1, fld(0, 64'h71, 0, 0), fld(0, 64'h72, 0, 0));
        push_exp(f); send(f, "t7a");
        chk("t7_proto_clean", 64'(o_proto_err), 64'd0);
        f = mk(1, 1, 1, 0, 4'h1, fld(1, 64'h73, 0, 0), fld(0, 64'h0, 0, 0));
        push_exp(f); send(f, "t7b");
        chk("t7_proto_set", 64'(o_proto_err), 64'd1);
        drain("t7");
        repeat (4) @(posedge clk);
        #1;
        chk("t7_proto_hold", 64'(o_proto_err), 64'd1);

        chk("sb_final_empty", 64'(q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
